nbit_serial_subtractor: RTL and testbench

NBIT_SERIAL_SUBTRACTOR -- requirements
Module: nbit_serial_subtractor

---
 rtl/nbit_serial_subtractor.sv | 129 ++++++++++++
 tb/tb_nbit_serial_subtractor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/nbit_serial_subtractor.sv
// Bit-serial subtract / NOT unit: one operand bit per clock, LSB first, result collected in a shift register.
// Latency N cycles from the accepted start to done; start is ignored while busy.
module nbit_serial_subtractor #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         b_in,
    input  logic [2:0]   oppcode,
    output logic [N-1:0] overall_out,
    output logic         b_out,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [2:0]    op_q, op_d;
    logic          br_q, br_d;
    logic [N-1:0]  sr_q, sr_d;
    logic [N-1:0]  out_q, out_d;
    logic          bout_q, bout_d;

    logic bit_a, bit_b, res_bit, br_nx;

    // Per-bit datapath for the operation latched at start.
    always_comb begin
        bit_a   = a_q[cnt_q];
        bit_b   = b_q[cnt_q];
        res_bit = 1'b0;
        br_nx   = 1'b0;
        case (op_q)
            OP_SUB: begin
                res_bit = bit_a ^ bit_b ^ br_q;
                br_nx   = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
            end
            OP_NOT: begin
                res_bit = ~bit_a;
                br_nx   = 1'b0;
            end
            default: begin
                res_bit = 1'b0;
                br_nx   = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        br_d    = br_q;
        sr_d    = sr_q;
        out_d   = out_q;
        bout_d  = bout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = oppcode;
                    br_d    = (oppcode == OP_SUB) ? b_in : 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sr_d = {res_bit, sr_q[N-1:1]};
                br_d = br_nx;
                if (cnt_q == LAST) begin
                    // Counter parks at LAST so it never wraps inside RUN.
                    out_d   = {res_bit, sr_q[N-1:1]};
                    bout_d  = br_nx;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            br_q    <= 1'b0;
            sr_q    <= '0;
            out_q   <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            br_q    <= br_d;
            sr_q    <= sr_d;
            out_q   <= out_d;
            bout_q  <= bout_d;
        end
    end

    assign overall_out = out_q;
    assign b_out       = bout_q;
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_nbit_serial_subtractor.sv
// Directed bench for the N=8 serial subtractor: latency, results, reset and back-to-back behaviour.
module tb_nbit_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       b_in;
    logic [2:0] op;
    logic [7:0] overall_out;
    logic       b_out;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    nbit_serial_subtractor #(.N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .b_in       (b_in),
        .oppcode    (op),
        .overall_out(overall_out),
        .b_out      (b_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ibin, input logic [2:0] iop);
        @(negedge clk);
        a = ia; b = ib; b_in = ibin; op = iop; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns edges from the start edge to the edge after which done is seen; -1 on timeout.
    task automatic wait_done(output int lat, output int busy_n);
        lat = -1;
        busy_n = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n - 1;
                break;
            end
            if (busy) busy_n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0; op = 3'b001;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (overall_out !== 8'h00) begin errors++; $display("FAIL reset_out got %h want 00", overall_out); end
        checks++; if (b_out !== 1'b0) begin errors++; $display("FAIL reset_bout got %b want 0", b_out); end
        // rst wins over start at the same edge
        start = 1'b1; a = 8'h55;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_priority_busy got %b want 0", busy); end
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_sub;
        int lat, bn;
        issue(8'h05, 8'h03, 1'b0, 3'b001);
        wait_done(lat, bn);
        checks++; if (lat !== 8) begin errors++; $display("FAIL sub1_latency got %0d want 8", lat); end
        checks++; if (bn !== 8) begin errors++; $display("FAIL sub1_busy_cycles got %0d want 8", bn); end
        checks++; if (overall_out !== 8'h02) begin errors++; $display("FAIL sub1_out got %h want 02", overall_out); end
        checks++; if (b_out !== 1'b0) begin errors++; $display("FAIL sub1_bout got %b want 0", b_out); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", done); end

        issue(8'h03, 8'h05, 1'b0, 3'b001);
        wait_done(lat, bn);
        checks++; if (overall_out !== 8'hFE) begin errors++; $display("FAIL sub2_out got %h want FE", overall_out); end
        checks++; if (b_out !== 1'b1) begin errors++; $display("FAIL sub2_bout got %b want 1", b_out); end

        issue(8'h00, 8'h00, 1'b1, 3'b001);
        wait_done(lat, bn);
        checks++; if (overall_out !== 8'hFF) begin errors++; $display("FAIL sub3_out got %h want FF", overall_out); end
        checks++; if (b_out !== 1'b1) begin errors++; $display("FAIL sub3_bout got %b want 1", b_out); end
    endtask

    task automatic test_not_reserved;
        int lat, bn;
        issue(8'hA5, 8'hFF, 1'b1, 3'b000);
        wait_done(lat, bn);
        checks++; if (overall_out !== 8'h5A) begin errors++; $display("FAIL not_out got %h want 5A", overall_out); end
        checks++; if (b_out !== 1'b0) begin errors++; $display("FAIL not_bout got %b want 0", b_out); end

        issue(8'hFF, 8'h01, 1'b1, 3'b111);
        wait_done(lat, bn);
        checks++; if (lat !== 8) begin errors++; $display("FAIL rsv_latency got %0d want 8", lat); end
        checks++; if (overall_out !== 8'h00) begin errors++; $display("FAIL rsv_out got %h want 00", overall_out); end
        checks++; if (b_out !== 1'b0) begin errors++; $display("FAIL rsv_bout got %b want 0", b_out); end
    endtask

    task automatic test_ignore_inputs;
        int dcount;
        dcount = 0;
        issue(8'h10, 8'h01, 1'b0, 3'b001);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) dcount++;
            if (i == 4) begin
                checks++; if (overall_out !== 8'h00) begin errors++; $display("FAIL hold_during_run got %h want 00", overall_out); end
            end
            if (i < 8) begin
                a = ~a; b = b + 8'h3C; b_in = ~b_in; op = 3'b000;
            end
            start = (i == 2);
            if (i == 2) begin a = 8'hEE; b = 8'h77; end
        end
        checks++; if (dcount !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", dcount); end
        checks++; if (overall_out !== 8'h0F) begin errors++; $display("FAIL ignore_out got %h want 0F", overall_out); end
    endtask

    task automatic test_reset_mid_run;
        int lat, bn, dcount;
        dcount = 0;
        issue(8'hFF, 8'h01, 1'b0, 3'b001);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (overall_out !== 8'h00) begin errors++; $display("FAIL abort_out got %h want 00", overall_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (b_out !== 1'b0) begin errors++; $display("FAIL abort_bout got %b want 0", b_out); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        checks++; if (dcount !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", dcount); end
        issue(8'h09, 8'h04, 1'b0, 3'b001);
        wait_done(lat, bn);
        checks++; if (lat !== 8) begin errors++; $display("FAIL post_rst_latency got %0d want 8", lat); end
        checks++; if (overall_out !== 8'h05) begin errors++; $display("FAIL post_rst_out got %h want 05", overall_out); end
    endtask

    task automatic test_back_to_back;
        int last, pulses;
        last = -1;
        pulses = 0;
        @(negedge clk);
        a = 8'h20; b = 8'h01; b_in = 1'b0; op = 3'b001; start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                checks++; if (overall_out !== 8'h1F) begin errors++; $display("FAIL b2b_out got %h want 1F", overall_out); end
                checks++; if (b_out !== 1'b0) begin errors++; $display("FAIL b2b_bout got %b want 0", b_out); end
                if (last >= 0) begin
                    checks++; if (i - last !== 9) begin errors++; $display("FAIL b2b_period got %0d want 9", i - last); end
                end
                last = i;
            end
        end
        start = 1'b0;
        checks++; if (pulses !== 4) begin errors++; $display("FAIL b2b_pulses got %0d want 4", pulses); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sub();
        test_not_reserved();
        test_ignore_inputs();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
